// File: rtl/pipelined_cpu_core.sv
// pipelined_cpu_core
// Three-stage (fetch / execute / writeback) CPU core. It has a byte-loadable
// program memory, a generic-width register file, ALU-result bypassing,
// taken-branch flush, a sticky HALT state and a saturating retired-instruction
// counter.
//
// Ports:
//   clk           in   1            clock, rising edge
//   rst           in   1            synchronous active-high reset
//   pmWrEn        in   1            program-memory byte write enable
//   pmAddr        in   PM_ADDWIDTH  program-memory byte address (little-endian)
//   instructionIn in   8            byte to write
//   aluresult     out  DATAWIDTH    writeback-stage result (wbData)
//   pc            out  PM_ADDWIDTH-2 fetch word address
//   halted        out  1            core has executed HALT
//   retired       out  CNTWIDTH     executed non-NOP instructions, saturating
//
// Core state:
//   state    | meaning
//   RUN_S    | fetching and executing normally
//   HALTED_S | HALT executed; pc frozen, ir held at NOP until rst
module pipelined_cpu_core #(
    parameter int DATAWIDTH   = 32,
    parameter int PM_ADDWIDTH = 8,
    parameter int REGADD      = 5,
    parameter int CNTWIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pmWrEn,
    input  logic [PM_ADDWIDTH-1:0] pmAddr,
    input  logic [7:0]             instructionIn,
    output logic [DATAWIDTH-1:0]   aluresult,
    output logic [PM_ADDWIDTH-3:0] pc,
    output logic                   halted,
    output logic [CNTWIDTH-1:0]    retired
);

    localparam int PCW   = PM_ADDWIDTH - 2;
    localparam int WORDS = 2 ** PCW;
    localparam int NREGS = 2 ** REGADD;

    localparam logic [6:0] OP_ADD  = 7'h01;
    localparam logic [6:0] OP_SUB  = 7'h02;
    localparam logic [6:0] OP_AND  = 7'h03;
    localparam logic [6:0] OP_OR   = 7'h04;
    localparam logic [6:0] OP_XOR  = 7'h05;
    localparam logic [6:0] OP_SLL  = 7'h06;
    localparam logic [6:0] OP_SRL  = 7'h07;
    localparam logic [6:0] OP_LDI  = 7'h10;
    localparam logic [6:0] OP_BEQ  = 7'h20;
    localparam logic [6:0] OP_JMP  = 7'h21;
    localparam logic [6:0] OP_HALT = 7'h7F;

    typedef enum logic {
        RUN_S    = 1'b0,
        HALTED_S = 1'b1
    } coreState_t;

    coreState_t state, stateNext;

    logic [31:0]           pm [WORDS];
    logic [DATAWIDTH-1:0]  regs [NREGS];
    logic [31:0]           ir;
    logic [PCW-1:0]        pcReg;
    logic                  wbEn;
    logic [REGADD-1:0]     wbAddr;
    logic [DATAWIDTH-1:0]  wbData;
    logic [CNTWIDTH-1:0]   retiredReg;

    logic [6:0]            opcode;
    logic [REGADD-1:0]     rd, rs1, rs2;
    logic [19:0]           imm20;
    logic [PCW-1:0]        target;
    logic [DATAWIDTH-1:0]  srcA, srcB, shAmt, result;
    logic                  writeEn, branchTaken, opHalt, retire;

    assign opcode = ir[6:0];
    assign rd     = ir[7 +: REGADD];
    assign rs1    = ir[12 +: REGADD];
    assign rs2    = ir[17 +: REGADD];
    assign imm20  = ir[31:12];
    assign target = ir[22 +: PCW];

    // Operand read: r0 is hard zero and never bypassed.
    always_comb begin
        srcA = '0;
        srcB = '0;
        if (rs1 != '0) srcA = (wbEn && wbAddr == rs1) ? wbData : regs[rs1];
        if (rs2 != '0) srcB = (wbEn && wbAddr == rs2) ? wbData : regs[rs2];
    end

    assign shAmt = srcB % DATAWIDTH'(DATAWIDTH);

    always_comb begin
        result      = '0;
        writeEn     = 1'b0;
        branchTaken = 1'b0;
        opHalt      = 1'b0;
        retire      = 1'b0;
        unique case (opcode)
            OP_ADD:  begin result = srcA + srcB;   writeEn = 1'b1; end
            OP_SUB:  begin result = srcA - srcB;   writeEn = 1'b1; end
            OP_AND:  begin result = srcA & srcB;   writeEn = 1'b1; end
            OP_OR:   begin result = srcA | srcB;   writeEn = 1'b1; end
            OP_XOR:  begin result = srcA ^ srcB;   writeEn = 1'b1; end
            OP_SLL:  begin result = srcA << shAmt; writeEn = 1'b1; end
            OP_SRL:  begin result = srcA >> shAmt; writeEn = 1'b1; end
            OP_LDI:  begin result[19:0] = imm20;   writeEn = 1'b1; end
            OP_BEQ:  begin branchTaken = (srcA == srcB); retire = 1'b1; end
            OP_JMP:  begin branchTaken = 1'b1;           retire = 1'b1; end
            OP_HALT: begin opHalt = 1'b1;                retire = 1'b1; end
            default: ;
        endcase
        if (writeEn) retire = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN_S;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (state == RUN_S && opHalt) stateNext = HALTED_S;
    end

    // Program memory is not reset; a same-cycle fetch sees the old word.
    always_ff @(posedge clk) begin
        if (pmWrEn) pm[pmAddr[PM_ADDWIDTH-1:2]][{pmAddr[1:0], 3'b000} +: 8] <= instructionIn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcReg      <= '0;
            ir         <= '0;
            wbEn       <= 1'b0;
            wbAddr     <= '0;
            wbData     <= '0;
            retiredReg <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            // Fetch; a taken branch or HALT replaces the fetched word with a NOP.
            if (state == RUN_S) begin
                if (opHalt) begin
                    ir <= '0;
                end else if (branchTaken) begin
                    ir    <= '0;
                    pcReg <= target;
                end else begin
                    ir    <= pm[pcReg];
                    pcReg <= pcReg + 1'b1;
                end
            end

            wbEn <= writeEn;
            if (writeEn) begin
                wbData <= result;
                wbAddr <= rd;
            end

            if (wbEn && wbAddr != '0) regs[wbAddr] <= wbData;

            if (retire && retiredReg != '1) retiredReg <= retiredReg + 1'b1;
        end
    end

    assign aluresult = wbData;
    assign pc        = pcReg;
    assign halted    = (state == HALTED_S);
    assign retired   = retiredReg;

endmodule

// File: tb/tb_pipelined_cpu_core.sv
// Testbench for pipelined_cpu_core: loads directed programs under reset and
// checks the per-cycle trace of aluresult/pc/halted/retired via a scoreboard.
// The retired counter is built 3 bits wide so saturation is reachable.
module tb_pipelined_cpu_core;

    localparam int DW  = 32;
    localparam int PAW = 8;
    localparam int RA  = 5;
    localparam int CW  = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           pmWrEn = 1'b0;
    logic [PAW-1:0] pmAddr = '0;
    logic [7:0]     instructionIn = '0;
    logic [DW-1:0]  aluresult;
    logic [PAW-3:0] pc;
    logic           halted;
    logic [CW-1:0]  retired;

    pipelined_cpu_core #(
        .DATAWIDTH(DW), .PM_ADDWIDTH(PAW), .REGADD(RA), .CNTWIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .pmWrEn(pmWrEn), .pmAddr(pmAddr),
        .instructionIn(instructionIn), .aluresult(aluresult), .pc(pc),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [5:0]  pc;
        logic        h;
        logic [2:0]  ret;
    } exp_t;

    exp_t        expQ[$];
    exp_t        cur;
    logic [31:0] prog [64];
    int          checks = 0;
    int          failures = 0;
    int          sampleIdx = 0;
    bit          monOn = 1'b0;
    string       tag = "";

    localparam logic [31:0] HALT = 32'h0000_007F;
    localparam logic [31:0] NOP  = 32'h0;

    function automatic logic [31:0] rIns(input logic [6:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2);
        return {10'd0, rs2, rs1, rd, op};
    endfunction

    function automatic logic [31:0] ldi(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'h10};
    endfunction

    function automatic logic [31:0] br(input logic [6:0] op, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [9:0] tgt);
        return {tgt, rs2, rs1, 5'd0, op};
    endfunction

    task automatic push(input logic [31:0] a, input int p, input bit h, input int r);
        expQ.push_back({a, 6'(p), h, 3'(r)});
    endtask

    task automatic clearProg();
        for (int i = 0; i < 64; i++) prog[i] = NOP;
    endtask

    // Writes all 64 words byte by byte while the core is held in reset.
    task automatic loadProgram();
        rst = 1'b1;
        monOn = 1'b0;
        for (int w = 0; w < 64; w++) begin
            for (int b = 0; b < 4; b++) begin
                pmWrEn        = 1'b1;
                pmAddr        = {w[5:0], b[1:0]};
                instructionIn = prog[w][8*b +: 8];
                @(posedge clk); #1;
            end
        end
        pmWrEn = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic startRun(input string name);
        tag       = name;
        sampleIdx = 0;
        rst       = 1'b0;
        monOn     = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expQ.size() > 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (expQ.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: %0d samples still pending, required 0", tag, expQ.size());
            expQ.delete();
        end
        monOn = 1'b0;
        rst   = 1'b1;
    endtask

    always @(negedge clk) begin
        if (monOn && expQ.size() > 0) begin
            cur = expQ.pop_front();
            checks++;
            if ({aluresult, pc, halted, retired} !== cur) begin
                failures++;
                $display("FAIL %s[%0d]: got alu=%h pc=%0d halted=%0b retired=%0d, required alu=%h pc=%0d halted=%0b retired=%0d",
                         tag, sampleIdx, aluresult, pc, halted, retired,
                         cur.alu, cur.pc, cur.h, cur.ret);
            end
            sampleIdx++;
        end
    end

    task automatic progA();
        clearProg();
        prog[0] = ldi(1, 20'd5);
        prog[1] = ldi(2, 20'd7);
        prog[2] = rIns(7'h01, 3, 1, 2);
        prog[3] = HALT;
    endtask

    task automatic pushA();
        push(32'd0, 1, 0, 0);
        push(32'd5, 2, 0, 1);
        push(32'd7, 3, 0, 2);
        push(32'd12, 4, 0, 3);
        push(32'd12, 4, 1, 4);
        push(32'd12, 4, 1, 4);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;

        // Dependency chain
        progA();
        loadProgram();
        push(32'd0, 0, 0, 0);
        pushA();
        startRun("depchain");
        drain();

        // Bypass chain
        clearProg();
        prog[0] = ldi(1, 20'd3);
        prog[1] = rIns(7'h01, 1, 1, 1);
        prog[2] = rIns(7'h01, 1, 1, 1);
        prog[3] = rIns(7'h02, 2, 0, 1);
        prog[4] = HALT;
        loadProgram();
        push(32'd0, 0, 0, 0);
        push(32'd0, 1, 0, 0);
        push(32'd3, 2, 0, 1);
        push(32'd6, 3, 0, 2);
        push(32'd12, 4, 0, 3);
        push(32'hFFFF_FFF4, 5, 0, 4);
        push(32'hFFFF_FFF4, 5, 1, 5);
        push(32'hFFFF_FFF4, 5, 1, 5);
        startRun("bypass");
        drain();

        // Branch flush
        clearProg();
        prog[0] = ldi(1, 20'd1);
        prog[1] = br(7'h20, 1, 1, 10'd4);
        prog[2] = ldi(5, 20'd9);
        prog[3] = NOP;
        prog[4] = rIns(7'h01, 6, 5, 0);
        prog[5] = HALT;
        loadProgram();
        push(32'd0, 0, 0, 0);
        push(32'd0, 1, 0, 0);
        push(32'd1, 2, 0, 1);
        push(32'd1, 4, 0, 2);
        push(32'd1, 5, 0, 2);
        push(32'd0, 6, 0, 3);
        push(32'd0, 6, 1, 4);
        push(32'd0, 6, 1, 4);
        startRun("branch");
        drain();

        // r0 handling
        clearProg();
        prog[0] = ldi(0, 20'hFFFFF);
        prog[1] = rIns(7'h01, 1, 0, 0);
        prog[2] = HALT;
        loadProgram();
        push(32'd0, 0, 0, 0);
        push(32'd0, 1, 0, 0);
        push(32'h000F_FFFF, 2, 0, 1);
        push(32'd0, 3, 0, 2);
        push(32'd0, 3, 1, 3);
        push(32'd0, 3, 1, 3);
        startRun("r0");
        drain();

        // Shifts: 33 mod 32 = 1, then 2 >> 1
        clearProg();
        prog[0] = ldi(1, 20'd1);
        prog[1] = ldi(2, 20'd33);
        prog[2] = rIns(7'h06, 3, 1, 2);
        prog[3] = rIns(7'h07, 4, 3, 1);
        prog[4] = HALT;
        loadProgram();
        push(32'd0, 0, 0, 0);
        push(32'd0, 1, 0, 0);
        push(32'd1, 2, 0, 1);
        push(32'd33, 3, 0, 2);
        push(32'd2, 4, 0, 3);
        push(32'd1, 5, 0, 4);
        push(32'd1, 5, 1, 5);
        push(32'd1, 5, 1, 5);
        startRun("shift");
        drain();

        // Logic ops, BEQ not taken, JMP squash, retired saturation at 7
        clearProg();
        prog[0] = ldi(1, 20'hF0F0F);
        prog[1] = ldi(2, 20'h0FF00);
        prog[2] = rIns(7'h03, 3, 1, 2);
        prog[3] = rIns(7'h04, 4, 1, 2);
        prog[4] = rIns(7'h05, 5, 1, 2);
        prog[5] = br(7'h20, 1, 2, 10'd0);
        prog[6] = br(7'h21, 0, 0, 10'd8);
        prog[7] = ldi(6, 20'h12345);
        prog[8] = HALT;
        loadProgram();
        push(32'd0, 0, 0, 0);
        push(32'd0, 1, 0, 0);
        push(32'h000F_0F0F, 2, 0, 1);
        push(32'h0000_FF00, 3, 0, 2);
        push(32'h0000_0F00, 4, 0, 3);
        push(32'h000F_FF0F, 5, 0, 4);
        push(32'h000F_F00F, 6, 0, 5);
        push(32'h000F_F00F, 7, 0, 6);
        push(32'h000F_F00F, 8, 0, 7);
        push(32'h000F_F00F, 9, 0, 7);
        push(32'h000F_F00F, 9, 1, 7);
        push(32'h000F_F00F, 9, 1, 7);
        startRun("logicjmp");
        drain();

        // Mid-program reset for one cycle, then a full identical rerun
        progA();
        loadProgram();
        push(32'd0, 0, 0, 0);
        push(32'd0, 1, 0, 0);
        push(32'd5, 2, 0, 1);
        push(32'd0, 0, 0, 0);
        pushA();
        startRun("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drain();

        // Reset while halted
        tag = "haltreset";
        sampleIdx = 0;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        push(32'd0, 0, 0, 0);
        monOn = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_cpu_core.md
# pipelined_cpu_core

Parametrised successor to the tiny CPU top level. A three-stage (fetch / execute / writeback) core with byte-loadable program memory, generic-width register file, full ALU-result bypassing, taken-branch flush, a HALT state and a retired-instruction counter. It is the CPU top level used by the design harness; program memory is written serially over an 8-bit port while the core is held in reset.

## Interface
- DATAWIDTH, 32: register and ALU width; must be ≥ 20.
- PM_ADDWIDTH, 8: program-memory byte-address width; the memory holds 2^(PM_ADDWIDTH-2) 32-bit words; must be 3..12.
- REGADD, 5: register-address width, 1..5; 2^REGADD registers.
- CNTWIDTH, 16: retired-instruction counter width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- pmWrEn  in  1  program-memory byte write enable; honoured in any cycle.
- pmAddr  in  PM_ADDWIDTH  byte address; the word at index pmAddr[PM_ADDWIDTH-1:2] holds byte pmAddr[1:0] in little-endian order.
- instructionIn  in  8  byte to write.
- aluresult  out  DATAWIDTH  registered writeback-stage result.
- pc  out  PM_ADDWIDTH-2  fetch word address.
- halted  out  1  core has executed HALT.
- retired  out  CNTWIDTH  count of executed non-NOP instructions; saturates at all-ones.

## Operation
- Instruction encoding: opcode [6:0], rd [11:7], rs1 [16:12], rs2 [21:17], imm20 [31:12], branch target [31:22]. Address fields use their low REGADD bits; the target uses its low PM_ADDWIDTH-2 bits.
- Opcodes:
  - 0x00 NOP
  - 0x01 ADD, 0x02 SUB, 0x03 AND, 0x04 OR, 0x05 XOR
  - 0x06 SLL, 0x07 SRL: shift amount is rs2 value mod DATAWIDTH.
  - 0x10 LDI: rd ← zero-extended imm20.
  - 0x20 BEQ: if rs1 == rs2, branch to the target.
  - 0x21 JMP: branch to the target.
  - 0x7F HALT
  - Any other opcode executes as NOP.
- Arithmetic is modulo 2^DATAWIDTH; no flags.
- Register r0 always reads 0; writes to r0 are discarded and not bypassed.
- Fetch stage: ir ← pm[pc]; pc ← pc+1, wrapping from the last word to 0.
- Execute stage:
  - Decode ir and read rs1/rs2.
  - Bypass: if wb_en is set and wb_addr equals the source register (nonzero), the source value is wb_data.
  - For ALU ops and LDI: wb_data ← result, wb_addr ← rd, wb_en ← 1.
  - Otherwise wb_en ← 0 and wb_data holds its previous value.
- Writeback stage: if wb_en is set and wb_addr ≠ 0, regs[wb_addr] ← wb_data at the end of the cycle. aluresult = wb_data.
- Taken branch (BEQ true, or JMP) in execute: pc ← target, ir ← NOP. The fall-through instruction is squashed.
- HALT in execute:
  - halted ← 1, ir ← NOP, pc frozen.
  - The write already in the writeback stage completes.
  - The core stays halted until rst.
- retired increments by 1 for each executed ALU, LDI, BEQ (taken or not), JMP or HALT instruction. It does not increment for NOPs, including squash bubbles.
- Program memory:
  - Not reset.
  - Byte writes take effect at the edge.
  - A fetch in the same cycle as a write to the same word returns the old contents.

## Timing
- Reset values:
  - pc = 0, ir = NOP
  - wb_en = 0, wb_addr = 0, wb_data = 0 (so aluresult = 0)
  - all registers 0
  - halted = 0, retired = 0
- rst takes priority over every other action, including mid-program and while halted. Program memory writes still occur during rst.
- First cycle after rst deasserts: pc = 0 is fetched. The word-0 instruction executes in cycle 2 and its result appears on aluresult in cycle 3.
- Steady state: one instruction per cycle; execute-to-aluresult latency is 1 cycle.
- Back-to-back dependencies need no stall (bypass).
- Taken branch penalty: 1 bubble cycle.
- halted rises the cycle after HALT executes. aluresult then holds the last writeback value.

## Test plan
- Dependency chain. Program: LDI r1,5; LDI r2,7; ADD r3,r1,r2; HALT. Required: aluresult = 5, 7, 12 on consecutive cycles; halted = 1; retired = 4; pc frozen.
- Bypass chain. Program: LDI r1,3; ADD r1,r1,r1; ADD r1,r1,r1; SUB r2,r0,r1. Required: aluresult = 3, 6, 12, then 0xFFFFFFF4 (DATAWIDTH = 32).
- Branch flush. Program: LDI r1,1; BEQ r1,r1 → word 4; LDI r5,9; NOP; ADD r6,r5,r0; HALT. Required: r5 is never written; aluresult shows 1 then 0; retired = 4.
- r0 handling. Program: LDI r0,0xFFFFF; ADD r1,r0,r0. Required: aluresult = 0xFFFFF, then 0.
- Shifts. Program: LDI r1,1; LDI r2,33; SLL r3,r1,r2. Required: aluresult = 2 (33 mod 32).
- Reset. Assert rst mid-program for 1 cycle. Required: next cycle pc = 0, aluresult = 0, halted = 0, retired = 0; the program reruns from word 0 with identical results.
